// File: rtl/avr_spi_slave.sv
// avr_spi_slave
// -----------------------------------------------------------------------------
// SPI slave (mode 0, MSB first) for the AVR-to-FPGA link. The AVR is the
// master; this block oversamples SS/SCK/MOSI in the system clock domain and
// exchanges whole bytes with the Picoblaze through one RX holding register
// and one TX holding register.
//
// Parameters
//   SYNC_STAGES  synchronizer depth for the SPI pins (2 or more)
//
// Ports
//   clk        system clock (50 MHz), sole clock
//   rst        asynchronous active-high reset
//   spiSs      slave select from AVR, active low
//   spiSck     SPI clock from AVR (at most clk/8)
//   spiMosi    AVR -> FPGA serial data
//   spiMiso    FPGA -> AVR serial data, high impedance while deselected
//   txData     byte to transmit, written by txLoad
//   txLoad     one-cycle write strobe for txData
//   txFull     TX holding register occupied
//   rxData     last received byte
//   rxValid    rxData holds an unread byte
//   rxAck      one-cycle read strobe, clears rxValid and rxOverrun
//   rxOverrun  sticky: a byte completed while rxValid was still set
//   busy       synchronized SS is asserted
// -----------------------------------------------------------------------------
module avr_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spiSs,
    input  logic       spiSck,
    input  logic       spiMosi,
    output logic       spiMiso,
    input  logic [7:0] txData,
    input  logic       txLoad,
    output logic       txFull,
    output logic [7:0] rxData,
    output logic       rxValid,
    input  logic       rxAck,
    output logic       rxOverrun,
    output logic       busy
);

    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   ss_hist;
    logic                   sck_hist;

    logic ss_s;
    logic sck_s;
    logic mosi_s;
    logic ss_low;
    logic ss_fall;
    logic sck_rise;
    logic sck_fall;
    logic byte_done;
    logic tx_fetch;
    logic consume;

    // The received byte's last bit goes straight from MOSI into rxData, so
    // only seven bits of shift history are ever needed.
    logic [6:0] rx_shift;
    logic [7:0] tx_shift;
    logic [2:0] bit_cnt;
    logic       load_pend;
    logic [7:0] tx_buf;
    logic [7:0] tx_next;

    // Pin synchronizers plus one history flop for SS and SCK edge detection.
    // SS idles high so that a reset never looks like a select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_sync   <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            ss_hist   <= 1'b1;
            sck_hist  <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spiSs};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spiSck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spiMosi};
            ss_hist   <= ss_sync[SYNC_STAGES-1];
            sck_hist  <= sck_sync[SYNC_STAGES-1];
        end
    end

    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // SCK edges only count while selected; an SS fall takes priority over any
    // SCK edge landing on the same cycle.
    assign ss_low    = ~ss_s;
    assign ss_fall   = ~ss_s & ss_hist;
    assign sck_rise  = ss_low & ~ss_fall & sck_s & ~sck_hist;
    assign sck_fall  = ss_low & ~ss_fall & ~sck_s & sck_hist;
    assign byte_done = sck_rise & (bit_cnt == 3'd7);

    // A fresh TX byte is fetched at select time and on the first SCK fall
    // after each completed byte; an empty buffer sends zeros.
    assign tx_fetch = ss_fall | (sck_fall & load_pend);
    assign consume  = tx_fetch & txFull;
    assign tx_next  = txFull ? tx_buf : 8'h00;

    // Shift registers and bit counter. Deselecting clears the byte framing,
    // so a partial byte is simply never completed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_shift  <= '0;
            tx_shift  <= '0;
            bit_cnt   <= '0;
            load_pend <= 1'b0;
        end else if (!ss_low) begin
            bit_cnt   <= '0;
            load_pend <= 1'b0;
        end else if (ss_fall) begin
            bit_cnt   <= '0;
            load_pend <= 1'b0;
            tx_shift  <= tx_next;
        end else begin
            if (sck_rise) begin
                rx_shift <= {rx_shift[5:0], mosi_s};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    load_pend <= 1'b1;
                end
            end
            if (sck_fall) begin
                if (load_pend) begin
                    tx_shift  <= tx_next;
                    load_pend <= 1'b0;
                end else begin
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

    // TX holding register. A write landing on the consumption cycle is kept:
    // the old byte has already gone to the shifter, so the buffer stays full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_buf <= '0;
            txFull <= 1'b0;
        end else if (consume) begin
            if (txLoad) begin
                tx_buf <= txData;
            end else begin
                txFull <= 1'b0;
            end
        end else if (txLoad && !txFull) begin
            tx_buf <= txData;
            txFull <= 1'b1;
        end
    end

    // RX holding register and flags. An acknowledge on the completion cycle
    // reads the old byte, so the new one is not an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxData    <= '0;
            rxValid   <= 1'b0;
            rxOverrun <= 1'b0;
        end else begin
            if (byte_done) begin
                rxData  <= {rx_shift, mosi_s};
                rxValid <= 1'b1;
            end else if (rxAck) begin
                rxValid <= 1'b0;
            end
            if (rxAck) begin
                rxOverrun <= 1'b0;
            end else if (byte_done && rxValid) begin
                rxOverrun <= 1'b1;
            end
        end
    end

    assign busy    = ss_low;
    assign spiMiso = ss_low ? tx_shift[7] : 1'bz;

endmodule
